// File: rtl/instr_fetch_sequencer.sv
// instr_fetch_sequencer: fetches instructions from a combinational memory and issues them to execute with handshake, step mode, redirects and halt
module instr_fetch_sequencer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5,
  parameter logic [2:0] HALT_OP = 3'b111
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              step_mode,
  input  logic              step,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic [ADDR_W-1:0] pc,
  output logic [2:0]        state,
  output logic              halted,
  output logic              wrapped,
  output logic [7:0]        issue_count
);
  typedef enum logic [2:0] {IDLE = 3'd0, FETCH = 3'd1, ISSUE = 3'd2, WAIT_STEP = 3'd3, HALT = 3'd4} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic wrapped_q, wrapped_d;
  logic [7:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] pc_inc;
  logic at_top, is_halt;
  assign pc_inc = pc_q + 1'b1;
  assign at_top = &pc_q;
  assign is_halt = instr_q[DATA_W-1 -: 3] == HALT_OP;
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    instr_d = instr_q;
    wrapped_d = wrapped_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE, HALT: if (start) begin
        state_d = FETCH;
        pc_d = '0;
        wrapped_d = 1'b0;
        cnt_d = '0;
      end
      FETCH: if (redirect_valid) pc_d = redirect_target;
        else begin
          instr_d = imem_data;
          state_d = ISSUE;
        end
      ISSUE: if (instr_ready) begin
        cnt_d = &cnt_q ? cnt_q : cnt_q + 8'd1;
        // a halt instruction always advances sequentially, ignoring redirect
        pc_d = (redirect_valid && !is_halt) ? redirect_target : pc_inc;
        wrapped_d = wrapped_q | (at_top & (is_halt | ~redirect_valid));
        state_d = is_halt ? HALT : step_mode ? WAIT_STEP : FETCH;
      end
      WAIT_STEP: if (redirect_valid) pc_d = redirect_target;
        else if (step || !step_mode) state_d = FETCH;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q <= '0;
      instr_q <= '0;
      wrapped_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      instr_q <= instr_d;
      wrapped_q <= wrapped_d;
      cnt_q <= cnt_d;
    end
  end
  assign imem_addr = pc_q;
  assign pc = pc_q;
  assign instr = instr_q;
  assign state = state_q;
  assign instr_valid = state_q == ISSUE;
  assign halted = state_q == HALT;
  assign wrapped = wrapped_q;
  assign issue_count = cnt_q;
endmodule
